// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared constants and types for the multi-cycle RV32M divider.
//   - op encodings for DIV/DIVU/REM/REMU (bit0 = unsigned, bit1 = remainder)
//   - FSM state encoding for div_unit
package div_unit_pkg;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    // Bit positions within op
    localparam int unsigned DIV_OP_UNSIGNED_BIT = 0;
    localparam int unsigned DIV_OP_REM_BIT      = 1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_FIX  = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring divider for DIV, DIVU, REM, REMU.
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         request, sampled only while idle (flush has priority)
//   op            bit0 = unsigned, bit1 = remainder
//   a, b          dividend / divisor, sampled with start
//   flush         synchronous kill of the in-flight operation
//   busy          registered stall request, high while an operation is in flight
//   done          one-cycle pulse, result valid in that cycle
//   result        quotient or remainder, held until the next done
// Normal ops take 32 CALC cycles plus one FIX cycle; divide-by-zero and signed
// overflow are resolved at accept and go straight to FIX.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state;
    logic [XLEN:0]   rem;        // partial remainder, one spare bit for the shifted value
    logic [XLEN-1:0] quo;        // dividend shifts out of the top, quotient bits in at the bottom
    logic [XLEN-1:0] dvsr;
    logic [CW-1:0]   cnt;
    logic            neg_quo;
    logic            neg_rem;
    logic            sel_rem;

    // Accept-time operand decode
    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            ovf;

    always_comb begin
        is_signed = ~op[DIV_OP_UNSIGNED_BIT];
        a_neg     = is_signed & a[XLEN-1];
        b_neg     = is_signed & b[XLEN-1];
        // INT_MIN negates to itself, which is the correct unsigned magnitude
        a_mag     = a_neg ? (~a + 1'b1) : a;
        b_mag     = b_neg ? (~b + 1'b1) : b;
        div_zero  = (b == '0);
        ovf       = is_signed & (a == INT_MIN) & (b == '1);
    end

    // One restoring step
    logic [XLEN:0] rem_sh;
    logic          take;

    always_comb begin
        rem_sh = {rem[XLEN-1:0], quo[XLEN-1]};
        take   = (rem_sh >= {1'b0, dvsr});
    end

    // Sign fix-up applied in FIX
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    always_comb begin
        quo_fix = neg_quo ? (~quo + 1'b1) : quo;
        rem_fix = neg_rem ? (~rem[XLEN-1:0] + 1'b1) : rem[XLEN-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= DIV_IDLE;
            rem     <= '0;
            quo     <= '0;
            dvsr    <= '0;
            cnt     <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            sel_rem <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= DIV_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    DIV_IDLE: begin
                        if (start) begin
                            busy    <= 1'b1;
                            sel_rem <= op[DIV_OP_REM_BIT];
                            cnt     <= '0;
                            if (div_zero || ovf) begin
                                // Final values loaded directly; FIX passes them through
                                state   <= DIV_FIX;
                                neg_quo <= 1'b0;
                                neg_rem <= 1'b0;
                                quo     <= div_zero ? '1 : INT_MIN;
                                rem     <= div_zero ? {1'b0, a} : '0;
                            end else begin
                                state   <= DIV_CALC;
                                neg_quo <= a_neg ^ b_neg;
                                neg_rem <= a_neg;
                                quo     <= a_mag;
                                rem     <= '0;
                                dvsr    <= b_mag;
                            end
                        end
                    end
                    DIV_CALC: begin
                        rem <= take ? (rem_sh - {1'b0, dvsr}) : rem_sh;
                        quo <= {quo[XLEN-2:0], take};
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_STEP) begin
                            state <= DIV_FIX;
                        end
                    end
                    DIV_FIX: begin
                        result <= sel_rem ? rem_fix : quo_fix;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DIV_IDLE;
                    end
                    default: begin
                        state <= DIV_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized checks of div_unit against a cycle-count
// reference model built from RISC-V division semantics.
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    div_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_special(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
        return (y == 32'h0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    endfunction

    // RISC-V reference semantics
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        sx = x;
        sy = y;
        if (y == 32'h0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
            return o[1] ? 32'h0 : 32'h8000_0000;
        if (o[0]) return o[1] ? (x % y) : (x / y);
        return o[1] ? 32'(sx % sy) : 32'(sx / sy);
    endfunction

    // Reference model: count down the remaining cycles of the accepted operation
    logic        m_busy;
    logic        m_done;
    logic [31:0] m_result;
    logic [31:0] m_pending;
    int          m_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_result <= 32'h0;
            m_left   <= 0;
        end else begin
            m_done <= 1'b0;
            if (flush) begin
                m_left <= 0;
                m_busy <= 1'b0;
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done   <= 1'b1;
                    m_busy   <= 1'b0;
                    m_result <= m_pending;
                end
            end else if (start) begin
                m_pending <= ref_div(op, a, b);
                m_left    <= is_special(op, a, b) ? 1 : 33;
                m_busy    <= 1'b1;
            end
        end
    end

    // Every-cycle comparison, away from the active edge
    always @(negedge clk) begin
        check("busy", {31'h0, busy}, {31'h0, m_busy});
        check("done", {31'h0, done}, {31'h0, m_done});
        check("result", result, m_result);
    end

    // Called at posedge+1; returns at posedge+1 in the done cycle
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
        int lat = 0;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1 start = 1'b0;
        check({name, " busy_after_accept"}, {31'h0, busy}, 32'h1);
        while (!done && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " result"}, result, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_done;
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        a     = 32'h0;
        b     = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset done", {31'h0, done}, 32'h0);
        check("reset result", result, 32'h0);

        // Hand-computed expectations
        run_op("divu 100/7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu 100%7", DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op("div -7/2", DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem -7%2", DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("div by 0", DIV_OP_DIV, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1);
        run_op("rem by 0", DIV_OP_REM, 32'h1234, 32'h0, 32'h1234, 1);
        run_op("divu by 0", DIV_OP_DIVU, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1);
        run_op("div ovf", DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem ovf", DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
        run_op("divu 100/7 again", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 33);

        // Flush at cycle 10 of CALC: no done, result holds 14
        start = 1'b1; op = DIV_OP_DIVU; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush busy", {31'h0, busy}, 32'h0);
        seen_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done) seen_done++;
        end
        check("flush no done", 32'(seen_done), 32'h0);
        check("flush result held", result, 32'd14);

        // start while busy is ignored
        start = 1'b1; op = DIV_OP_DIVU; a = 32'd100; b = 32'd6;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 start = 1'b1; a = 32'd50; b = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        seen_done = 0;
        repeat (60) begin
            @(posedge clk);
            #1 if (done) seen_done++;
        end
        check("busy start one done", 32'(seen_done), 32'h1);
        check("busy start result", result, 32'd16);

        // flush together with start in idle
        start = 1'b1; flush = 1'b1; op = DIV_OP_DIVU; a = 32'd1; b = 32'd1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        check("flush+start busy", {31'h0, busy}, 32'h0);
        @(posedge clk);
        #1 check("flush+start done", {31'h0, done}, 32'h0);

        // Asynchronous reset mid-CALC
        start = 1'b1; op = DIV_OP_DIVU; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst busy", {31'h0, busy}, 32'h0);
        check("async rst done", {31'h0, done}, 32'h0);
        check("async rst result", result, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_op("divu 9/3 after rst", DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

        // Randomized, mostly back-to-back, with occasional flushes
        for (int i = 0; i < 150; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 16));
                3: rb = -32'($urandom_range(1, 16));
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) begin
                start = 1'b1; op = ro; a = ra; b = rb;
                @(posedge clk);
                #1 start = 1'b0;
                repeat ($urandom_range(0, 34)) @(posedge clk);
                #1 flush = 1'b1;
                @(posedge clk);
                #1 flush = 1'b0;
            end else begin
                run_op("random", ro, ra, rb, ref_div(ro, ra, rb),
                       is_special(ro, ra, rb) ? 1 : 33);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle integer divider for the RV32M divide/remainder group (DIV, DIVU, REM, REMU). It sits beside the ALU in the execute stage and is fed from the same forwarded operand pair. Its result is merged into the execute-stage result mux. While it runs, `busy` tells the hazard unit to stall the front of the pipeline. The ALU's combinational `/` and `%` paths are retired once this block is integrated.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request; sampled only in IDLE
- `op`  in  2  bit0 = unsigned, bit1 = remainder (00 DIV, 01 DIVU, 10 REM, 11 REMU)
- `a`  in  XLEN  dividend; sampled with `start`
- `b`  in  XLEN  divisor; sampled with `start`
- `flush`  in  1  synchronous kill of the in-flight operation
- `busy`  out  1  operation in flight; the stall request
- `done`  out  1  one-cycle pulse; `result` valid in this cycle
- `result`  out  XLEN  quotient or remainder, held until the next `done`

## Operation
- Algorithm: radix-2 restoring division on magnitudes.
  - Datapath: 33-bit partial remainder, 32-bit quotient shift register, 5-bit iteration counter.
  - Signed ops convert `a` and `b` to magnitudes at accept. Sign flags are latched.
- States and transitions:
  - IDLE → CALC when `start` is high on a normal case.
  - IDLE → FIX when `start` is high on a special case.
  - CALC stays for 32 cycles, then → FIX.
  - FIX → IDLE.
- CALC step, once per cycle:
  - `rem = {rem, q[31]}`, `q <<= 1`.
  - If `rem ≥ divisor`, then `rem -= divisor` and `q[0] = 1`.
- FIX:
  - Negate the quotient when signed and the sign of `a` differs from the sign of `b`.
  - Negate the remainder when signed and `a` is negative.
  - Select quotient or remainder per `op[1]`. Register it into `result` and pulse `done`.
- Special cases (RISC-V semantics), decided at accept, skip CALC:
  - `b == 0`: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = `a`.
  - Signed, `a == 0x80000000`, `b == 0xFFFFFFFF`: quotient = 0x80000000; remainder = 0.
- `start` while busy is ignored. The upstream stall already holds the instruction stable.
- `flush`:
  - Forces IDLE. `busy` = 0 and `done` = 0 from the next cycle.
  - `result` is unchanged.
  - `flush` and `start` in the same cycle: flush wins and nothing is accepted.
- `rst` is asynchronous, including mid-operation. It forces IDLE with `busy` = 0, `done` = 0, `result` = 0 and counter = 0.

## Timing
- Let E0 be the edge that samples `start` in IDLE.
- Normal case:
  - `busy` rises after E0.
  - CALC covers edges E1 through E32.
  - FIX completes at E33. `done` = 1 and `busy` = 0 for the cycle after E33.
  - Latency is 33 cycles from accept to `done`.
- Special case:
  - E0 → FIX, then E1 → IDLE with `done` high after E1.
  - Latency is 1 cycle. `busy` is high for exactly one cycle.
- `done` is registered and lasts exactly one cycle, always coincident with IDLE.
- Back-to-back: a `start` in the `done` cycle is accepted. Normal-case throughput is one operation per 34 cycles.
- `result` updates only at the edge that raises `done`.
- `busy` is a registered output with no combinational input-to-output path. The hazard unit combines `busy` with the decode-stage DIV/REM indication for stall timing.

## Structure
- Add to `defines.v`:
  - The `op` encoding constants: `DIV_OP_DIV`, `DIV_OP_DIVU`, `DIV_OP_REM`, `DIV_OP_REMU`.
  - The state encodings: `DIV_IDLE`, `DIV_CALC`, `DIV_FIX` (2 bits).
- Decode maps the existing `ALU_DIV`, `ALU_DIVU`, `ALU_REM` and `ALU_REMU` codes onto `start` and `op`.
- Single flat module. No sub-module is warranted: the conditional-subtract step and sign fix are a few lines each.
- Target is roughly 150–250 lines of RTL.

## Test plan
- DIVU, a=100, b=7 → `done` 33 cycles after accept, `result` = 14; repeat with REMU → 2.
- DIV, a=-7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD; REM on the same operands → 0xFFFFFFFF.
- Divide by zero, b=0, a=0x1234:
  - DIV → 0xFFFFFFFF and REM → 0x1234.
  - `done` arrives 1 cycle after accept and `busy` is high for one cycle.
- Overflow, DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM on the same operands → 0; 1-cycle latency.
- Flush and extra starts:
  - `flush` at cycle 10 of CALC → IDLE, no `done`, `result` keeps the prior value.
  - A `start` issued while busy is never executed.
  - `flush` together with `start` in IDLE → nothing is accepted.
- `rst` asserted mid-CALC, asynchronously between edges → `busy`, `done` and `result` go to 0 immediately. A new DIVU, a=9, b=3 then returns 3 on schedule.
